// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter that queues single-cycle button press pulses as button
// indices in a small FIFO, presented to the consumer over valid/ready.
module btn_event_arbiter #(
    parameter int unsigned N_BTN = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic             evt_ready,
    input  logic             clr_err,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [CNT_W-1:0] fifo_level,
    output logic             err_overrun,
    output logic             err_full
);

    localparam int unsigned PTR_W = CNT_W - 1;

    logic [N_BTN-1:0] pending;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             fifo_full;
    logic             grant_ok;
    logic [ID_W-1:0]  grant_id;
    logic [N_BTN-1:0] grant_mask;
    logic             push;
    logic             pop;
    logic             overrun_evt;
    logic             full_evt;

    assign fifo_full = (fifo_level == CNT_W'(DEPTH));
    assign evt_valid = (fifo_level != '0);
    assign evt_id    = evt_valid ? mem[rd_ptr] : '0;
    assign push      = grant_ok;
    assign pop       = evt_valid & evt_ready;

    // Search upward from rr_ptr with wrap; first set pending bit wins.
    always_comb begin
        logic [ID_W:0] idx;
        grant_ok = 1'b0;
        grant_id = '0;
        idx      = '0;
        if (!fifo_full) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(N_BTN))
                    idx = idx - (ID_W+1)'(N_BTN);
                if (!grant_ok && pending[idx[ID_W-1:0]]) begin
                    grant_ok = 1'b1;
                    grant_id = idx[ID_W-1:0];
                end
            end
        end
    end

    assign grant_mask  = grant_ok ? (N_BTN'(1) << grant_id) : '0;
    assign overrun_evt = |(btn_pulse & pending & ~grant_mask);
    assign full_evt    = (|pending) & fifo_full;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            err_overrun <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            // A pulse on the bit being granted re-arms it rather than being dropped.
            pending <= (pending & ~grant_mask) | btn_pulse;

            if (grant_ok) begin
                if (grant_id == ID_W'(N_BTN - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant_id + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            if (overrun_evt)
                err_overrun <= 1'b1;
            else if (clr_err)
                err_overrun <= 1'b0;

            if (full_evt)
                err_full <= 1'b1;
            else if (clr_err)
                err_full <= 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr] <= grant_id;
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter using immediate assertions.
module tb_btn_event_arbiter;

    logic       sysclk;
    logic       reset;
    logic [3:0] btn_pulse;
    logic       evt_ready;
    logic       clr_err;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [2:0] fifo_level;
    logic       err_overrun;
    logic       err_full;

    int n_checks = 0;
    int n_fail   = 0;

    btn_event_arbiter #(.N_BTN(4), .ID_W(2), .DEPTH(4), .CNT_W(3)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .btn_pulse   (btn_pulse),
        .evt_ready   (evt_ready),
        .clr_err     (clr_err),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .fifo_level  (fifo_level),
        .err_overrun (err_overrun),
        .err_full    (err_full)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; btn_pulse = '0; evt_ready = 1'b0; clr_err = 1'b0;
        #3;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovr", 32'(err_overrun), 0);
        chk("rst_full", 32'(err_full), 0);
        tick();
        reset = 1'b0;

        // 1. single press, valid for exactly one cycle two clocks after pulse
        btn_pulse = 4'b0100; evt_ready = 1'b1;
        tick();
        btn_pulse = '0;
        chk("t1_valid_k", 32'(evt_valid), 0);
        tick();
        chk("t1_valid_k1", 32'(evt_valid), 1);
        chk("t1_id", 32'(evt_id), 2);
        chk("t1_level", 32'(fifo_level), 1);
        tick();
        chk("t1_valid_k2", 32'(evt_valid), 0);
        chk("t1_id_idle", 32'(evt_id), 0);
        chk("t1_level_k2", 32'(fifo_level), 0);

        // 2. simultaneous presses from rr_ptr=0
        reset = 1'b1; #2; reset = 1'b0;
        btn_pulse = 4'b1011; evt_ready = 1'b1;
        tick();
        btn_pulse = '0;
        tick();
        chk("t2_id0", 32'(evt_id), 0);
        chk("t2_v0", 32'(evt_valid), 1);
        tick();
        chk("t2_id1", 32'(evt_id), 1);
        chk("t2_lvl1", 32'(fifo_level), 1);
        tick();
        chk("t2_id3", 32'(evt_id), 3);
        tick();
        chk("t2_empty", 32'(evt_valid), 0);
        chk("t2_rr", 32'(dut.rr_ptr), 0);

        // 3. fairness: bits 0 and 3 every other cycle; grants alternate 0,3,...
        for (int j = 0; j < 20; j++) begin
            btn_pulse = (j % 2 == 0) ? 4'b1001 : 4'b0000;
            tick();
            if (j >= 1) begin
                chk("t3_valid", 32'(evt_valid), 1);
                chk("t3_id", 32'(evt_id), (j % 2 == 1) ? 0 : 3);
            end
        end
        btn_pulse = '0;
        repeat (4) tick();
        chk("t3_drain_valid", 32'(evt_valid), 0);
        chk("t3_drain_pend", 32'(dut.pending), 0);
        chk("t3_ovr", 32'(err_overrun), 0);
        chk("t3_full", 32'(err_full), 0);

        // 4. full FIFO holds the pending press until a pop frees a slot
        evt_ready = 1'b0;
        btn_pulse = 4'b0001; tick();
        btn_pulse = 4'b0010; tick();
        btn_pulse = 4'b0100; tick();
        btn_pulse = 4'b1000; tick();
        btn_pulse = 4'b0010; tick();
        btn_pulse = 4'b0000; tick();
        chk("t4_level", 32'(fifo_level), 4);
        chk("t4_err_full", 32'(err_full), 1);
        chk("t4_pend", 32'(dut.pending), 4'b0010);
        chk("t4_head", 32'(evt_id), 0);
        chk("t4_ovr", 32'(err_overrun), 0);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("t4_pop_level", 32'(fifo_level), 3);
        chk("t4_pop_head", 32'(evt_id), 1);
        chk("t4_pop_pend", 32'(dut.pending), 4'b0010);
        tick();
        chk("t4_refill", 32'(fifo_level), 4);
        chk("t4_pend_clr", 32'(dut.pending), 0);

        // 5. overrun on a stalled button, then clear flags
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t5_clr_full", 32'(err_full), 0);
        btn_pulse = 4'b0100; tick();
        btn_pulse = 4'b0000; tick();
        btn_pulse = 4'b0100; tick();
        btn_pulse = 4'b0000;
        chk("t5_ovr", 32'(err_overrun), 1);
        chk("t5_full", 32'(err_full), 1);
        chk("t5_pend", 32'(dut.pending), 4'b0100);
        evt_ready = 1'b1;
        tick(); chk("t5_d1_id", 32'(evt_id), 2); chk("t5_d1_lvl", 32'(fifo_level), 3);
        tick(); chk("t5_d2_id", 32'(evt_id), 3); chk("t5_d2_lvl", 32'(fifo_level), 3);
        tick(); chk("t5_d3_id", 32'(evt_id), 1); chk("t5_d3_lvl", 32'(fifo_level), 2);
        tick(); chk("t5_d4_id", 32'(evt_id), 2); chk("t5_d4_lvl", 32'(fifo_level), 1);
        tick(); chk("t5_d5_valid", 32'(evt_valid), 0); chk("t5_d5_lvl", 32'(fifo_level), 0);
        tick(); chk("t5_ready_empty", 32'(fifo_level), 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t5_clr_ovr", 32'(err_overrun), 0);
        chk("t5_clr_full2", 32'(err_full), 0);

        // 6. async reset mid-cycle with three queued events
        evt_ready = 1'b0;
        btn_pulse = 4'b1011; tick();
        btn_pulse = 4'b0000;
        repeat (3) tick();
        chk("t6_level3", 32'(fifo_level), 3);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_ovr", 32'(err_overrun), 0);
        chk("t6_rst_full", 32'(err_full), 0);
        chk("t6_rst_pend", 32'(dut.pending), 0);
        reset = 1'b0;
        btn_pulse = 4'b0001; evt_ready = 1'b1;
        tick();
        btn_pulse = 4'b0000;
        chk("t6_post_k", 32'(evt_valid), 0);
        tick();
        chk("t6_post_valid", 32'(evt_valid), 1);
        chk("t6_post_id", 32'(evt_id), 0);
        tick();
        chk("t6_post_pop", 32'(evt_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
